// File: rtl/frame_dump_ctrl_pkg.sv
// Shared types and constants for the frame dump sequencer and its UART pacing.
package frame_dump_ctrl_pkg;

  localparam int DEF_COLS    = 40;
  localparam int DEF_ROWS    = 30;
  localparam int DEF_HOLDOFF = 8191;

  localparam logic [7:0] HDR_SYNC0 = 8'hA5;
  localparam logic [7:0] HDR_SYNC1 = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_HDR,
    ST_FETCH,
    ST_SEND,
    ST_DONE
  } dump_state_e;

  // Byte idx 0 is the most significant byte of the word.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_pacer.sv
// Write-permit generator for a byte UART: enforces an idle holdoff after busy
// falls and forbids back-to-back strobes.
module uart_pacer #(
  parameter int HOLDOFF = 8191
) (
  input  logic clk,
  input  logic rst_n,
  input  logic uart_busy,
  input  logic wr_strobe,
  output logic permit
);

  localparam int CW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [CW-1:0] CMAX = CW'(HOLDOFF);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (uart_busy)          cnt_d = '0;
    else if (cnt_q != CMAX) cnt_d = cnt_q + 1'b1;
  end

  // Starts saturated so the first byte after reset goes out without delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= CMAX;
    else        cnt_q <= cnt_d;
  end

  assign permit = (cnt_q == CMAX) && !uart_busy && !wr_strobe;

endmodule

// File: rtl/frame_dump_ctrl.sv
// Streams one ROWS x COLS word frame out over the byte UART, MSB first.
// FRAME_DUMP_HEADER_EN: when defined, a 4-byte header (A5 5A COLS ROWS) precedes the pixel data.
module frame_dump_ctrl
  import frame_dump_ctrl_pkg::*;
#(
  parameter int COLS    = DEF_COLS,
  parameter int ROWS    = DEF_ROWS,
  parameter int HOLDOFF = DEF_HOLDOFF
) (
  input  logic        clk12,
  input  logic        areset_n,
  input  logic        start,
  input  logic        frame_end,
  output logic        freeze,
  output logic [5:0]  read_x,
  output logic [4:0]  read_y,
  input  logic [31:0] read_data,
  input  logic        uart_busy,
  output logic        uart_write,
  output logic [7:0]  uart_data,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] X_LAST = 6'(COLS - 1);
  localparam logic [4:0] Y_LAST = 5'(ROWS - 1);

  dump_state_e state_q, state_d;

  logic [1:0]  fe_sync_q, fe_sync_d;
  logic        fe_prev_q, fe_prev_d;
  logic [5:0]  x_q, x_d;
  logic [4:0]  y_q, y_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        wr_q, wr_d;
  logic [7:0]  data_q, data_d;

  logic frame_rise;
  logic permit;
  logic last_word;
  logic [7:0] hdr_byte;

  uart_pacer #(.HOLDOFF(HOLDOFF)) u_pacer (
    .clk       (clk12),
    .rst_n     (areset_n),
    .uart_busy (uart_busy),
    .wr_strobe (wr_q),
    .permit    (permit)
  );

  // frame_end is asynchronous; only a rising edge of the synchronised level counts.
  assign fe_sync_d  = {fe_sync_q[0], frame_end};
  assign fe_prev_d  = fe_sync_q[1];
  assign frame_rise = fe_sync_q[1] && !fe_prev_q;

  assign last_word = (x_q == X_LAST) && (y_q == Y_LAST);

  always_comb begin
    case (idx_q)
      2'd0:    hdr_byte = HDR_SYNC0;
      2'd1:    hdr_byte = HDR_SYNC1;
      2'd2:    hdr_byte = 8'(COLS);
      default: hdr_byte = 8'(ROWS);
    endcase
  end

  always_ff @(posedge clk12 or negedge areset_n) begin
    if (!areset_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ARM;
      ST_ARM:   if (frame_rise) begin
`ifdef FRAME_DUMP_HEADER_EN
        state_d = ST_HDR;
`else
        state_d = ST_FETCH;
`endif
      end
      ST_HDR:   if (permit && idx_q == 2'd3) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_SEND;
      ST_SEND:  if (permit && idx_q == 2'd3) state_d = last_word ? ST_DONE : ST_FETCH;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Status outputs decode straight from the state register so reset clears them at once.
  always_comb begin
    busy   = 1'b0;
    freeze = 1'b0;
    done   = 1'b0;
    case (state_q)
      ST_ARM:                   busy = 1'b1;
      ST_HDR, ST_FETCH, ST_SEND: begin
        busy   = 1'b1;
        freeze = 1'b1;
      end
      ST_DONE:                  done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    idx_d  = idx_q;
    word_d = word_q;
    wr_d   = 1'b0;
    data_d = data_q;
    case (state_q)
      ST_ARM: if (frame_rise) begin
        x_d   = '0;
        y_d   = '0;
        idx_d = '0;
      end
      ST_HDR: if (permit) begin
        wr_d   = 1'b1;
        data_d = hdr_byte;
        idx_d  = idx_q + 2'd1;
      end
      ST_FETCH: begin
        word_d = read_data;
        idx_d  = '0;
      end
      ST_SEND: if (permit) begin
        wr_d   = 1'b1;
        data_d = word_byte(word_q, idx_q);
        idx_d  = idx_q + 2'd1;
        // Address moves on the last byte so the next FETCH sees the new word.
        if (idx_q == 2'd3 && !last_word) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 5'd1;
          end else begin
            x_d = x_q + 6'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk12 or negedge areset_n) begin
    if (!areset_n) begin
      fe_sync_q <= '0;
      fe_prev_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      wr_q      <= 1'b0;
      data_q    <= '0;
    end else begin
      fe_sync_q <= fe_sync_d;
      fe_prev_q <= fe_prev_d;
      x_q       <= x_d;
      y_q       <= y_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      wr_q      <= wr_d;
      data_q    <= data_d;
    end
  end

  assign read_x     = x_q;
  assign read_y     = y_q;
  assign uart_write = wr_q;
  assign uart_data  = data_q;

endmodule

// File: doc/frame_dump_ctrl.md
# frame_dump_ctrl

Sequencer that streams one downsampled camera frame out of the downsample buffer over the debug UART. On a start request it waits for the next end-of-frame, freezes buffer writes, walks the ROWS×COLS word array in raster order, and emits each 32-bit word as four bytes MSB-first through the byte UART. It sits in the `clk12` domain between the downsample read port and the UART, replacing ad-hoc top-level dump logic.

## Interface
- `COLS`, 40, words per row; `read_x` wraps at `COLS-1`
- `ROWS`, 30, rows per frame
- `HOLDOFF`, 8191, idle cycles required after `uart_busy` falls before the next write
- `clk12` in 1: system clock, 12 MHz
- `areset_n` in 1: asynchronous active-low reset
- `start` in 1: single-cycle dump request
- `frame_end` in 1: level from capture domain (high outside the active frame), unsynchronised
- `freeze` out 1: high tells downsample to hold its contents
- `read_x` out 6: buffer column address
- `read_y` out 5: buffer row address
- `read_data` in 32: buffer word, valid one cycle after address change
- `uart_busy` in 1: UART transmitting
- `uart_write` out 1: one-cycle byte strobe
- `uart_data` out 8: byte to send, stable while `uart_write` high
- `busy` out 1: dump in progress
- `done` out 1: one-cycle pulse at dump completion

## Operation
- `frame_end` passes a 2-FF synchroniser; a rising edge of the synchronised level is a frame boundary.
- States: IDLE, ARM, HDR, FETCH, SEND, DONE.
- IDLE: `start` → ARM; `busy`=1. `start` during any non-IDLE state is ignored.
- ARM: wait for frame boundary → assert `freeze`, clear x/y/byte index; go to HDR (macro on) or FETCH.
- HDR: send 0xA5, 0x5A, then COLS, then ROWS (each under the write rule) → FETCH.
- FETCH: one cycle for `read_data` to settle → SEND, byte index 0.
- SEND: write rule satisfied → `uart_data` = byte[3-idx] of captured word (idx 0 = bits 31:24), `uart_write` pulses; idx 3 done → advance x (wrap at COLS-1, increment y) → FETCH; last byte of (COLS-1, ROWS-1) → DONE.
- Write rule: holdoff counter reset to 0 while `uart_busy`, otherwise saturating increment to HOLDOFF; write permitted only when counter = HOLDOFF, `uart_busy`=0, and no write in the previous cycle.
- DONE: `done` pulse, drop `freeze` and `busy` → IDLE.
- `read_data` captured into a word register at FETCH exit; later changes ignored.

## Timing
- Reset: all outputs 0, state IDLE, holdoff counter at HOLDOFF (first byte not delayed), synchroniser 0.
- `busy` rises the cycle after `start`; `freeze` the cycle after the synchronised edge (3 clocks after `frame_end` rises, worst case).
- Address → capture: 1 cycle (FETCH).
- Byte spacing ≥ UART busy time + HOLDOFF + 1 cycles.
- `done` and `freeze`/`busy` fall in the same cycle.
- Reset mid-dump: immediate return to IDLE, `freeze` drops asynchronously, no further writes.
- `frame_end` already high at `start`: wait for the next rising edge, never the current level.

## Configuration
- `FRAME_DUMP_HEADER_EN`: defined → HDR state sends the 4-byte header (A5 5A COLS ROWS) before pixel data; undefined → ARM goes directly to FETCH; stream is exactly 4·COLS·ROWS bytes.

## Structure
- Shared package: state enum, header constants 0xA5/0x5A, default COLS/ROWS.
- Sub-module `uart_pacer`: holdoff counter + write-permit logic, reused by other UART sources.

## Test plan
- Reset, `start`, toggle `frame_end` 0→1, UART model busy 100 cycles per byte, HOLDOFF=4 → header (if enabled) then 4800 bytes, order (0,0)…(39,29), MSB first, one `done`.
- `read_data` = {y,x,y,x} pattern → byte k equals expected field; addresses wrap x 39→0 with y+1.
- `frame_end` held high when `start` arrives → no `freeze` until it goes low then high again.
- Second `start` mid-dump → ignored, byte count unchanged.
- `areset_n` low after 1000 bytes → outputs 0 within the reset cycle; new `start` restarts from (0,0).
- `uart_busy` stuck high → no `uart_write`; releases → first write exactly HOLDOFF+1 cycles later.
